rtype_exec_unit: RTL and testbench

- Multi-cycle execute/writeback sequencer for MIPS R-type instructions.
- Sits between the instruction source and the 32x32 register file.
- Accepts one instruction word per handshake, drives the register file read addresses, latches operands, computes the ALU result, then issues a single-cycle register-file write.
- Produces result flags and a completion pulse.

---
 rtl/rtype_pkg.sv | 35 +++
 rtl/rtype_exec_unit_alu32.sv | 51 +++++
 rtl/rtype_exec_unit.sv | 122 ++++++++++++
 tb/tb_rtype_exec_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type execute/writeback sequencer:
// sequencer states, MIPS R-type opcode/funct codes and the overflow rule.
package rtype_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // For subtraction pass ~B as the second operand: A - B == A + ~B + 1.
    function automatic logic signedOverflow(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] sum);
        return (a[31] == b[31]) && (sum[31] != a[31]);
    endfunction

endpackage

// File: rtl/rtype_exec_unit_alu32.sv
// Purely combinational 32-bit R-type ALU; flags unknown funct codes as illegal
// and forces their result to zero.
module alu32
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_A,
    input  logic [DATA_W-1:0] i_B,
    input  logic [4:0]        i_Shamt,
    input  logic [5:0]        i_Funct,
    output logic [DATA_W-1:0] o_Result,
    output logic              o_Overflow,
    output logic              o_Illegal
);

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;

    assign w_sum  = i_A + i_B;
    assign w_diff = i_A - i_B;

    always_comb begin
        o_Result   = '0;
        o_Overflow = 1'b0;
        o_Illegal  = 1'b0;
        case (i_Funct)
            FN_ADD: begin
                o_Result   = w_sum;
                o_Overflow = signedOverflow(i_A, i_B, w_sum);
            end
            FN_ADDU: o_Result = w_sum;
            FN_SUB: begin
                o_Result   = w_diff;
                o_Overflow = signedOverflow(i_A, ~i_B, w_diff);
            end
            FN_SUBU: o_Result = w_diff;
            FN_AND:  o_Result = i_A & i_B;
            FN_OR:   o_Result = i_A | i_B;
            FN_XOR:  o_Result = i_A ^ i_B;
            FN_NOR:  o_Result = ~(i_A | i_B);
            FN_SLT:  o_Result = {{(DATA_W-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
            FN_SLTU: o_Result = {{(DATA_W-1){1'b0}}, (i_A < i_B)};
            FN_SLL:  o_Result = i_B << i_Shamt;
            FN_SRL:  o_Result = i_B >> i_Shamt;
            FN_SRA:  o_Result = $unsigned($signed(i_B) >>> i_Shamt);
            default: o_Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rtype_exec_unit.sv
// Four-state execute/writeback sequencer for MIPS R-type instructions:
// fetch operands from the register file, run the ALU, issue one write.
module rtype_exec_unit
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Inst_Valid,
    input  logic [31:0]       Inst,
    output logic              Inst_Ready,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    output logic              Done,
    output logic              ZF,
    output logic              OF,
    output logic              Illegal
);

    state_t            r_state;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_aluOut;
    logic              r_zf;
    logic              r_of;
    logic              r_illegal;
    logic              r_done;
    logic              r_writeReg;
    logic              r_instReady;

    logic [DATA_W-1:0] w_aluResult;
    logic              w_aluOverflow;
    logic              w_aluIllegal;
    logic              w_illegal;
    logic              w_overflow;
    logic [DATA_W-1:0] w_result;
    logic [ADDR_W-1:0] w_rd;

    alu32 #(.DATA_W(DATA_W)) u_alu (
        .i_A        (r_a),
        .i_B        (r_b),
        .i_Shamt    (r_ir[10:6]),
        .i_Funct    (r_ir[5:0]),
        .o_Result   (w_aluResult),
        .o_Overflow (w_aluOverflow),
        .o_Illegal  (w_aluIllegal)
    );

    // A non-zero opcode overrides whatever the ALU made of the funct field.
    assign w_illegal  = (r_ir[31:26] != OP_RTYPE) || w_aluIllegal;
    assign w_overflow = !w_illegal && w_aluOverflow;
    assign w_result   = w_illegal ? '0 : w_aluResult;
    assign w_rd       = r_ir[15:11];

    assign R_Addr_A   = r_ir[25:21];
    assign R_Addr_B   = r_ir[20:16];
    assign W_Addr     = w_rd;
    assign W_Data     = r_aluOut;
    assign Write_Reg  = r_writeReg;
    assign Done       = r_done;
    assign ZF         = r_zf;
    assign OF         = r_of;
    assign Illegal    = r_illegal;
    assign Inst_Ready = r_instReady;

    // The register file does not protect r0, so rd==0 must never be written.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_aluOut    <= '0;
            r_zf        <= 1'b0;
            r_of        <= 1'b0;
            r_illegal   <= 1'b0;
            r_done      <= 1'b0;
            r_writeReg  <= 1'b0;
            r_instReady <= 1'b1;
        end else begin
            r_done     <= 1'b0;
            r_writeReg <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Inst_Valid) begin
                        r_ir        <= Inst;
                        r_instReady <= 1'b0;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    r_a     <= R_Data_A;
                    r_b     <= R_Data_B;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_aluOut   <= w_result;
                    r_zf       <= (w_result == '0);
                    r_of       <= w_overflow;
                    r_illegal  <= w_illegal;
                    r_done     <= 1'b1;
                    r_writeReg <= !w_illegal && !w_overflow && (w_rd != '0);
                    r_state    <= WB;
                end
                WB: begin
                    r_instReady <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_exec_unit.sv
// Directed self-checking bench for rtype_exec_unit with a behavioural
// 32x32 register file attached to the read/write ports.
module tb_rtype_exec_unit;

    logic        Clk;
    logic        Reset;
    logic        Inst_Valid;
    logic [31:0] Inst;
    logic        Inst_Ready;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [31:0] R_Data_A;
    logic [31:0] R_Data_B;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic        Done;
    logic        ZF;
    logic        OF;
    logic        Illegal;

    logic [31:0] rf [32];
    logic        plEn;
    logic [4:0]  plAddr;
    logic [31:0] plData;

    int nCompared = 0;
    int nMismatched = 0;

    rtype_exec_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Inst_Valid (Inst_Valid),
        .Inst       (Inst),
        .Inst_Ready (Inst_Ready),
        .R_Addr_A   (R_Addr_A),
        .R_Addr_B   (R_Addr_B),
        .R_Data_A   (R_Data_A),
        .R_Data_B   (R_Data_B),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data),
        .Write_Reg  (Write_Reg),
        .Done       (Done),
        .ZF         (ZF),
        .OF         (OF),
        .Illegal    (Illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file: combinational reads, DUT writes plus a bench preload port.
    assign R_Data_A = rf[R_Addr_A];
    assign R_Data_B = rf[R_Addr_B];
    always @(posedge Clk) begin
        if (plEn) rf[plAddr] <= plData;
        if (Write_Reg) rf[W_Addr] <= W_Data;
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    task automatic advance(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        plEn = 1'b1;
        plAddr = addr;
        plData = data;
        @(posedge Clk);
        #1;
        plEn = 1'b0;
    endtask

    // Waits (bounded) for Inst_Ready, then holds Inst_Valid across one accept edge.
    task automatic applyStimulus(input logic [31:0] inst);
        int waitCycles = 0;
        while (Inst_Ready !== 1'b1 && waitCycles < 10) begin
            advance(1);
            waitCycles++;
        end
        nCompared++;
        if (Inst_Ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL ready_timeout: Inst_Ready=%b required 1", Inst_Ready); end
        Inst_Valid = 1'b1;
        Inst = inst;
        @(posedge Clk);
        #1;
        Inst_Valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Inst_Valid = 1'b1;
        Inst = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        plEn = 1'b0;
        plAddr = '0;
        plData = '0;
        #2;
        nCompared++; if (Inst_Ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_ready: got %b required 1", Inst_Ready); end
        nCompared++; if (Write_Reg !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_wr: got %b required 0", Write_Reg); end
        nCompared++; if (Done !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_done: got %b required 0", Done); end
        nCompared++; if ({ZF, OF, Illegal} !== 3'b000) begin nMismatched++; $display("[TB] FAIL rst_flags: got %b required 000", {ZF, OF, Illegal}); end
        advance(2);
        nCompared++; if (Inst_Ready !== 1'b1 || Write_Reg !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_held: ready=%b wr=%b required 1/0", Inst_Ready, Write_Reg); end
        Inst_Valid = 1'b0;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            advance(1);
            nCompared++; if (Write_Reg !== 1'b0 || Done !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_spurious: wr=%b done=%b required 0/0", Write_Reg, Done); end
        end
    endtask

    task automatic test_add();
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        applyStimulus(32'h00221820);
        nCompared++; if (R_Addr_A !== 5'd1 || R_Addr_B !== 5'd2) begin nMismatched++; $display("[TB] FAIL add_raddr: got %0d/%0d required 1/2", R_Addr_A, R_Addr_B); end
        nCompared++; if (Done !== 1'b0 || Inst_Ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_read_state: done=%b ready=%b required 0/0", Done, Inst_Ready); end
        advance(1);
        nCompared++; if (Done !== 1'b0 || Write_Reg !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_early: done=%b wr=%b required 0/0", Done, Write_Reg); end
        advance(1);
        nCompared++; if (Done !== 1'b1 || Write_Reg !== 1'b1) begin nMismatched++; $display("[TB] FAIL add_wb: done=%b wr=%b required 1/1", Done, Write_Reg); end
        nCompared++; if (W_Addr !== 5'd3 || W_Data !== 32'd12) begin nMismatched++; $display("[TB] FAIL add_wdata: addr=%0d data=%h required 3/0000000c", W_Addr, W_Data); end
        nCompared++; if (ZF !== 1'b0 || OF !== 1'b0 || Illegal !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_flags: zf=%b of=%b ill=%b required 000", ZF, OF, Illegal); end
        advance(1);
        nCompared++; if (Done !== 1'b0 || Write_Reg !== 1'b0 || Inst_Ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL add_after: done=%b wr=%b ready=%b required 0/0/1", Done, Write_Reg, Inst_Ready); end
        nCompared++; if (rf[3] !== 32'd12) begin nMismatched++; $display("[TB] FAIL add_commit: r3=%h required 0000000c", rf[3]); end
    endtask

    task automatic test_overflow();
        preload(5'd1, 32'h7FFF_FFFF);
        preload(5'd2, 32'd1);
        applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        advance(2);
        nCompared++; if (Done !== 1'b1 || OF !== 1'b1 || Write_Reg !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_of: done=%b of=%b wr=%b required 1/1/0", Done, OF, Write_Reg); end
        advance(1);
        nCompared++; if (rf[3] !== 32'd12) begin nMismatched++; $display("[TB] FAIL add_of_nowrite: r3=%h required 0000000c", rf[3]); end
        applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
        advance(2);
        nCompared++; if (W_Data !== 32'h8000_0000 || OF !== 1'b0 || Write_Reg !== 1'b1) begin nMismatched++; $display("[TB] FAIL addu_wrap: data=%h of=%b wr=%b required 80000000/0/1", W_Data, OF, Write_Reg); end
        advance(1);
        preload(5'd1, 32'h8000_0000);
        applyStimulus(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h22));
        advance(2);
        nCompared++; if (OF !== 1'b1 || Write_Reg !== 1'b0) begin nMismatched++; $display("[TB] FAIL sub_of: of=%b wr=%b required 1/0", OF, Write_Reg); end
        advance(1);
    endtask

    task automatic test_arith_shift();
        preload(5'd1, 32'h7FFF_FFFF);
        applyStimulus(rtype(5'd1, 5'd1, 5'd4, 5'd0, 6'h22));
        advance(2);
        nCompared++; if (W_Data !== 32'd0 || ZF !== 1'b1 || OF !== 1'b0 || Write_Reg !== 1'b1) begin nMismatched++; $display("[TB] FAIL sub_zero: data=%h zf=%b of=%b wr=%b required 0/1/0/1", W_Data, ZF, OF, Write_Reg); end
        advance(1);
        nCompared++; if (ZF !== 1'b1) begin nMismatched++; $display("[TB] FAIL zf_held: got %b required 1", ZF); end
        preload(5'd1, 32'hFFFF_FFFF);
        preload(5'd2, 32'd1);
        applyStimulus(rtype(5'd1, 5'd2, 5'd5, 5'd0, 6'h2A));
        advance(2);
        nCompared++; if (W_Data !== 32'd1 || ZF !== 1'b0) begin nMismatched++; $display("[TB] FAIL slt: data=%h zf=%b required 00000001/0", W_Data, ZF); end
        advance(1);
        applyStimulus(rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h2B));
        advance(2);
        nCompared++; if (W_Data !== 32'd0 || ZF !== 1'b1) begin nMismatched++; $display("[TB] FAIL sltu: data=%h zf=%b required 00000000/1", W_Data, ZF); end
        advance(1);
        preload(5'd2, 32'h8000_0000);
        applyStimulus(rtype(5'd0, 5'd2, 5'd7, 5'd4, 6'h03));
        advance(2);
        nCompared++; if (W_Data !== 32'hF800_0000) begin nMismatched++; $display("[TB] FAIL sra: data=%h required f8000000", W_Data); end
        advance(1);
        applyStimulus(rtype(5'd0, 5'd2, 5'd7, 5'd4, 6'h02));
        advance(2);
        nCompared++; if (W_Data !== 32'h0800_0000) begin nMismatched++; $display("[TB] FAIL srl: data=%h required 08000000", W_Data); end
        advance(1);
        applyStimulus(rtype(5'd0, 5'd1, 5'd7, 5'd4, 6'h00));
        advance(2);
        nCompared++; if (W_Data !== 32'hFFFF_FFF0) begin nMismatched++; $display("[TB] FAIL sll: data=%h required fffffff0", W_Data); end
        advance(1);
        preload(5'd1, 32'h0F0F_00FF);
        preload(5'd2, 32'h00FF_0F0F);
        applyStimulus(rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h27));
        advance(2);
        nCompared++; if (W_Data !== 32'hF000_F000) begin nMismatched++; $display("[TB] FAIL nor: data=%h required f000f000", W_Data); end
        advance(1);
        nCompared++; if (rf[7] !== 32'hF000_F000) begin nMismatched++; $display("[TB] FAIL nor_commit: r7=%h required f000f000", rf[7]); end
    endtask

    task automatic test_illegal();
        applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F));
        advance(2);
        nCompared++; if (Illegal !== 1'b1 || Write_Reg !== 1'b0 || Done !== 1'b1) begin nMismatched++; $display("[TB] FAIL ill_funct: ill=%b wr=%b done=%b required 1/0/1", Illegal, Write_Reg, Done); end
        nCompared++; if (ZF !== 1'b1 || OF !== 1'b0 || W_Data !== 32'd0) begin nMismatched++; $display("[TB] FAIL ill_result: zf=%b of=%b data=%h required 1/0/0", ZF, OF, W_Data); end
        advance(1);
        nCompared++; if (Illegal !== 1'b1 || Done !== 1'b0) begin nMismatched++; $display("[TB] FAIL ill_held: ill=%b done=%b required 1/0", Illegal, Done); end
        applyStimulus({6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20});
        advance(2);
        nCompared++; if (Illegal !== 1'b1 || Write_Reg !== 1'b0) begin nMismatched++; $display("[TB] FAIL ill_opcode: ill=%b wr=%b required 1/0", Illegal, Write_Reg); end
        advance(1);
        applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h25));
        advance(2);
        nCompared++; if (Done !== 1'b1 || Write_Reg !== 1'b0 || Illegal !== 1'b0) begin nMismatched++; $display("[TB] FAIL or_rd0: done=%b wr=%b ill=%b required 1/0/0", Done, Write_Reg, Illegal); end
        nCompared++; if (W_Data !== 32'h0FFF_0FFF) begin nMismatched++; $display("[TB] FAIL or_rd0_data: data=%h required 0fff0fff", W_Data); end
        advance(1);
    endtask

    task automatic test_back_to_back();
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        preload(5'd3, 32'hDEAD_BEEF);
        applyStimulus(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        advance(3);
        applyStimulus(rtype(5'd3, 5'd3, 5'd5, 5'd0, 6'h25));
        nCompared++; if (R_Addr_A !== 5'd3 || R_Addr_B !== 5'd3) begin nMismatched++; $display("[TB] FAIL b2b_raddr: got %0d/%0d required 3/3", R_Addr_A, R_Addr_B); end
        advance(2);
        nCompared++; if (W_Data !== 32'd12 || W_Addr !== 5'd5 || Write_Reg !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_raw: data=%h addr=%0d wr=%b required 0000000c/5/1", W_Data, W_Addr, Write_Reg); end
        advance(1);
    endtask

    task automatic test_reset_mid();
        preload(5'd8, 32'h0000_DEAD);
        applyStimulus(rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h20));
        advance(1);
        Reset = 1'b1;
        #1;
        nCompared++; if (Inst_Ready !== 1'b1 || Done !== 1'b0 || Write_Reg !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_async: ready=%b done=%b wr=%b required 1/0/0", Inst_Ready, Done, Write_Reg); end
        advance(1);
        nCompared++; if (Write_Reg !== 1'b0 || Done !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_nowb: wr=%b done=%b required 0/0", Write_Reg, Done); end
        Reset = 1'b0;
        advance(3);
        nCompared++; if (Inst_Ready !== 1'b1 || Write_Reg !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_idle: ready=%b wr=%b required 1/0", Inst_Ready, Write_Reg); end
        nCompared++; if (rf[8] !== 32'h0000_DEAD) begin nMismatched++; $display("[TB] FAIL midrst_commit: r8=%h required 0000dead", rf[8]); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_arith_shift();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
